// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// FSM encoding, port-select encoding for the round-robin pointer, default widths.
package rf_arb_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester/clear handshake and register-file write bus of rf_write_arbiter.
// master = requesters and register file side, slave = the arbiter.
interface rf_write_arbiter_if #(
  parameter int DW = rf_arb_pkg::DW_DEF,
  parameter int AW = rf_arb_pkg::AW_DEF
);
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_gnt;

  logic          b_req;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_gnt;

  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  logic          rf_write;
  logic [AW-1:0] rf_regw;
  logic [DW-1:0] rf_dataw;

  modport master (
    output a_req, a_addr, a_data, b_req, b_addr, b_data, clr_req,
    input  a_gnt, b_gnt, clr_busy, clr_done, rf_write, rf_regw, rf_dataw
  );

  modport slave (
    input  a_req, a_addr, a_data, b_req, b_addr, b_data, clr_req,
    output a_gnt, b_gnt, clr_busy, clr_done, rf_write, rf_regw, rf_dataw
  );
endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; ptr names the most recent winner.
// Purely combinational: the owner of ptr decides when it advances.
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // NOTE: assign a default before any branch so always_comb never infers a latch.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr == PORT_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between ports A and B and
// runs a one-register-per-cycle clear sequence with priority over both.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic               clock,
  input logic               reset,
  rf_write_arbiter_if.slave bus
);

  localparam logic [0:0]    S_IDLE   = IDLE;
  localparam logic [0:0]    S_CLEAR  = CLEAR;
  localparam logic [AW-1:0] CLR_LAST = '1;

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic          ptr;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          rf_write_q;
  logic [AW-1:0] rf_regw_q;
  logic [DW-1:0] rf_dataw_q;

  // Clear requests win outright, so grants are suppressed in the cycle clr_req is seen.
  assign arb_en = !reset && (state == S_IDLE) && !bus.clr_req;

  rr_arb2 u_arb (
    .req (({bus.b_req, bus.a_req})),
    .en  (arb_en),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign bus.a_gnt    = gnt[0];
  assign bus.b_gnt    = gnt[1];
  assign bus.clr_busy = !reset && (state == S_CLEAR);
  assign bus.clr_done = !reset && (state == S_CLEAR) && (clr_cnt == CLR_LAST);
  assign bus.rf_write = rf_write_q;
  assign bus.rf_regw  = rf_regw_q;
  assign bus.rf_dataw = rf_dataw_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      ptr        <= PORT_B;
      rf_write_q <= 1'b0;
      rf_regw_q  <= '0;
      rf_dataw_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.clr_req) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            rf_write_q <= 1'b1;
            rf_regw_q  <= '0;
            rf_dataw_q <= '0;
          end else begin
            rf_write_q <= |gnt;
            if (gnt[0]) begin
              rf_regw_q  <= bus.a_addr;
              rf_dataw_q <= bus.a_data;
              ptr        <= PORT_A;
            end else if (gnt[1]) begin
              rf_regw_q  <= bus.b_addr;
              rf_dataw_q <= bus.b_data;
              ptr        <= PORT_B;
            end
          end
        end
        S_CLEAR: begin
          // clr_cnt mirrors the register being written this cycle.
          if (clr_cnt == CLR_LAST) begin
            state      <= S_IDLE;
            rf_write_q <= 1'b0;
          end else begin
            clr_cnt    <= clr_cnt + AW'(1);
            rf_regw_q  <= clr_cnt + AW'(1);
            rf_dataw_q <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a cycle-level reference model plus a
// register-file image, compared every cycle, with hand-computed spot checks.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: clear step (-1 = not clearing), last winner, pending write, RF image.
  int         m_idx  = -1;
  logic       m_last = 1'b1;
  logic       m_wr   = 1'b0;
  logic [1:0] m_addr = 2'd0;
  logic [7:0] m_data = 8'd0;
  logic [7:0] rf [4];
  bit         chk_en = 1'b0;

  function automatic logic [1:0] model_gnt();
    if (reset || m_idx >= 0 || bus.clr_req) return 2'b00;
    if (bus.a_req && bus.b_req) return m_last ? 2'b01 : 2'b10;
    return {bus.b_req, bus.a_req};
  endfunction

  always @(posedge clock) begin
    logic [1:0] g;
    g = model_gnt();
    if (m_wr) rf[m_addr] = m_data;
    if (reset) begin
      m_idx = -1; m_last = 1'b1; m_wr = 1'b0; m_addr = 2'd0; m_data = 8'd0;
    end else if (m_idx >= 0) begin
      if (m_idx == 3) begin
        m_idx = -1; m_wr = 1'b0;
      end else begin
        m_idx++; m_addr = 2'(m_idx); m_data = 8'd0;
      end
    end else if (bus.clr_req) begin
      m_idx = 0; m_wr = 1'b1; m_addr = 2'd0; m_data = 8'd0;
    end else if (g[0]) begin
      m_wr = 1'b1; m_addr = bus.a_addr; m_data = bus.a_data; m_last = 1'b0;
    end else if (g[1]) begin
      m_wr = 1'b1; m_addr = bus.b_addr; m_data = bus.b_data; m_last = 1'b1;
    end else begin
      m_wr = 1'b0;
    end
  end

  always @(negedge clock) begin
    logic [1:0] g;
    if (chk_en) begin
      g = model_gnt();
      check("a_gnt", 32'(bus.a_gnt), 32'(g[0]));
      check("b_gnt", 32'(bus.b_gnt), 32'(g[1]));
      check("gnt_exclusive", 32'(bus.a_gnt & bus.b_gnt), 32'd0);
      check("rf_write", 32'(bus.rf_write), 32'(m_wr));
      check("clr_busy", 32'(bus.clr_busy), 32'(!reset && m_idx >= 0));
      check("clr_done", 32'(bus.clr_done), 32'(!reset && m_idx == 3));
      if (m_wr) begin
        check("rf_regw", 32'(bus.rf_regw), 32'(m_addr));
        check("rf_dataw", 32'(bus.rf_dataw), 32'(m_data));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic b_write(input logic [1:0] addr, input logic [7:0] data);
    bus.b_req = 1'b1; bus.b_addr = addr; bus.b_data = data;
    step();
    bus.b_req = 1'b0;
  endtask

  int n_wr, n_done;

  initial begin
    bus.a_req = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_req = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.clr_req = 1'b0;
    for (int i = 0; i < 4; i++) rf[i] = 8'd0;

    step(); step();
    chk_en = 1'b1;

    // Reset state, with a request already waiting
    bus.a_req = 1'b1; bus.a_addr = 2'd2; bus.a_data = 8'h5A;
    @(negedge clock);
    check("rst_gnt", 32'(bus.a_gnt), 32'd0);
    check("rst_rf_write", 32'(bus.rf_write), 32'd0);
    check("rst_rf_regw", 32'(bus.rf_regw), 32'd0);
    check("rst_rf_dataw", 32'(bus.rf_dataw), 32'd0);
    check("rst_busy_done", 32'({bus.clr_busy, bus.clr_done}), 32'd0);
    step();
    reset = 1'b0;

    // Single A write, one-cycle latency
    @(negedge clock);
    check("t1_a_gnt", 32'(bus.a_gnt), 32'd1);
    step();
    bus.a_req = 1'b0;
    @(negedge clock);
    check("t1_wr", 32'({bus.rf_write, bus.rf_regw, bus.rf_dataw}), 32'({1'b1, 2'd2, 8'h5A}));
    step();
    check("t1_rf_r2", 32'(rf[2]), 32'h5A);

    // Fresh pointer, then a 4-cycle tie: A, B, A, B
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a_req = 1'b1; bus.b_req = 1'b1;
      if (i == 0 || i % 2 == 1) begin bus.a_addr = 2'(i); bus.a_data = 8'hA0 + 8'(i); end
      if (i % 2 == 0) begin bus.b_addr = 2'(3 - i); bus.b_data = 8'hB0 + 8'(i); end
      @(negedge clock);
      check("tie_order", 32'({bus.b_gnt, bus.a_gnt}), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) check("tie_wr_hi", 32'(bus.rf_write), 32'd1);
      step();
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clock);
    check("tie_last_wr", 32'({bus.rf_write, bus.rf_regw, bus.rf_dataw}), 32'({1'b1, 2'd1, 8'hB2}));
    step();

    // Load 11,22,33,44 then clear with A pending
    for (int i = 0; i < 4; i++) b_write(2'(i), 8'(11 * (i + 1)));
    step();
    check("load_r3", 32'(rf[3]), 32'd44);
    bus.clr_req = 1'b1;
    bus.a_req = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'h77;
    @(negedge clock);
    check("clr_start_gnt", 32'(bus.a_gnt), 32'd0);
    step();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("clr_gnt", 32'(bus.a_gnt), 32'd0);
      check("clr_wr", 32'({bus.rf_write, bus.rf_regw, bus.rf_dataw}), 32'({1'b1, 2'(i), 8'h00}));
      check("clr_done_pulse", 32'(bus.clr_done), 32'(i == 3));
      step();
    end
    @(negedge clock);
    check("post_clr_gnt", 32'({bus.clr_busy, bus.a_gnt}), 32'd1);
    step();
    bus.a_req = 1'b0;
    step();
    check("clr_rf", 32'({rf[3], rf[2], rf[1], rf[0]}), 32'h0000_7700);

    // Reset during the second clear write
    b_write(2'd0, 8'h99); b_write(2'd2, 8'h33); b_write(2'd3, 8'h44);
    step();
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    step();
    reset = 1'b1;
    bus.a_req = 1'b1; bus.a_addr = 2'd3; bus.a_data = 8'hEE;
    @(negedge clock);
    check("rst_mid_regw", 32'(bus.rf_regw), 32'd1);
    check("rst_mid_gnt", 32'(bus.a_gnt), 32'd0);
    step();
    reset = 1'b0; bus.a_req = 1'b0;
    @(negedge clock);
    check("rst_mid_out", 32'({bus.rf_write, bus.rf_regw, bus.rf_dataw, bus.clr_busy, bus.clr_done}), 32'd0);
    step();
    check("rst_mid_rf", 32'({rf[3], rf[2], rf[0]}), 32'h44_33_00);

    // B alone three times, then a tie goes to A
    for (int i = 0; i < 3; i++) begin
      bus.b_req = 1'b1; bus.b_addr = 2'(i); bus.b_data = 8'hC0 + 8'(i);
      @(negedge clock);
      check("b_alone", 32'(bus.b_gnt), 32'd1);
      step();
    end
    bus.a_req = 1'b1; bus.a_addr = 2'd3; bus.a_data = 8'hD3;
    bus.b_addr = 2'd2; bus.b_data = 8'hD2;
    @(negedge clock);
    check("tie_after_b", 32'({bus.b_gnt, bus.a_gnt}), 32'd1);
    step();
    bus.a_req = 1'b0;
    step();
    bus.b_req = 1'b0;
    step();

    // Re-pulsing clr_req while busy does not extend the sequence
    bus.clr_req = 1'b1;
    step();
    n_wr = 0; n_done = 0;
    for (int i = 0; i < 7; i++) begin
      bus.clr_req = (i == 1 || i == 2);
      @(negedge clock);
      if (bus.rf_write) n_wr++;
      if (bus.clr_done) n_done++;
      step();
    end
    bus.clr_req = 1'b0;
    check("repulse_writes", 32'(n_wr), 32'd4);
    check("repulse_done", 32'(n_done), 32'd1);
    check("repulse_rf", 32'({rf[3], rf[2], rf[1], rf[0]}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
